// File: rtl/ysyx_22040895_muldiv_pkg.sv
// Shared encodings for the iterative RV64M multiply/divide unit.
package ysyx_22040895_muldiv_pkg;

  localparam int unsigned MD_XLEN = 64;

  // funct3 encodings of the M extension
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic md_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic md_is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // rs1 is treated as signed by mul, mulh, mulhsu, div, rem
  function automatic logic md_op1_signed(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  // rs2 is treated as signed by mul, mulh, div, rem
  function automatic logic md_op2_signed(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/ysyx_22040895_muldiv_sign.sv
// Combinational sign handling: operand extension and magnitude on the way in,
// negation, half selection and word sign-extension on the way out.
module ysyx_22040895_muldiv_sign
  import ysyx_22040895_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = MD_XLEN
) (
  input  logic [2:0]        op_i,
  input  logic              wordop_i,
  input  logic [XLEN-1:0]   op1_i,
  input  logic [XLEN-1:0]   op2_i,
  output logic [XLEN-1:0]   abs1_o,
  output logic [XLEN-1:0]   abs2_o,
  output logic              neg1_o,
  output logic              neg2_o,
  input  logic [2*XLEN-1:0] raw_i,
  input  logic              negate_i,
  input  logic              take_hi_i,
  input  logic              res_word_i,
  output logic [XLEN-1:0]   result_o
);

  logic              sgn1, sgn2;
  logic [XLEN-1:0]   sx1, zx1, sx2, zx2;
  logic [XLEN-1:0]   ext1, ext2;
  logic [2*XLEN-1:0] signed_raw;
  logic [XLEN-1:0]   sel;
  logic [XLEN-1:0]   sel_sx;

  // Extend operands to the working width and strip their signs
  always_comb begin
    sgn1 = md_op1_signed(op_i);
    sgn2 = md_op2_signed(op_i);
    sx1  = XLEN'($signed(op1_i[31:0]));
    zx1  = XLEN'(op1_i[31:0]);
    sx2  = XLEN'($signed(op2_i[31:0]));
    zx2  = XLEN'(op2_i[31:0]);
    ext1 = op1_i;
    ext2 = op2_i;
    if (wordop_i) begin
      ext1 = sgn1 ? sx1 : zx1;
      ext2 = sgn2 ? sx2 : zx2;
    end
    neg1_o = sgn1 & ext1[XLEN-1];
    neg2_o = sgn2 & ext2[XLEN-1];
    abs1_o = neg1_o ? -ext1 : ext1;
    abs2_o = neg2_o ? -ext2 : ext2;
  end

  // Negate the full-width magnitude first so the high half gets the borrow
  always_comb begin
    signed_raw = negate_i ? -raw_i : raw_i;
    sel        = take_hi_i ? signed_raw[2*XLEN-1:XLEN] : signed_raw[XLEN-1:0];
    sel_sx     = XLEN'($signed(sel[31:0]));
    result_o   = res_word_i ? sel_sx : sel;
  end

endmodule

// File: rtl/ysyx_22040895_muldiv.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional flush input enabled by defining YSYX_22040895_MULDIV_FLUSH_EN.
module ysyx_22040895_muldiv
  import ysyx_22040895_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = MD_XLEN
) (
  input  logic            clk,
  input  logic            rst,
`ifdef YSYX_22040895_MULDIV_FLUSH_EN
  input  logic            flush_i,
`endif
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      op_i,
  input  logic            wordop_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int unsigned CNTW = $clog2(XLEN + 1);

  md_state_e         state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              word_q, word_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   opb_q, opb_d;    // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] prod_q, prod_d;  // product; low half doubles as dividend/quotient
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              flush;
  logic              accept, last, special;
  logic              div0, ovf;
  logic [XLEN-1:0]   dvd_sx, spec_res;
  logic [XLEN-1:0]   abs1, abs2;
  logic              neg1, neg2;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN:0]     div_shift, div_diff, div_rem_nxt;
  logic [XLEN-1:0]   div_quo_nxt;
  logic [2*XLEN-1:0] fin_raw;
  logic              fin_hi;
  logic [XLEN-1:0]   fin_res;

`ifdef YSYX_22040895_MULDIV_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  ysyx_22040895_muldiv_sign #(
    .XLEN (XLEN)
  ) u_sign (
    .op_i       (op_i),
    .wordop_i   (wordop_i),
    .op1_i      (op1_i),
    .op2_i      (op2_i),
    .abs1_o     (abs1),
    .abs2_o     (abs2),
    .neg1_o     (neg1),
    .neg2_o     (neg2),
    .raw_i      (fin_raw),
    .negate_i   (neg_q),
    .take_hi_i  (fin_hi),
    .res_word_i (word_q),
    .result_o   (fin_res)
  );

  assign accept      = in_valid_i && (state_q == MD_IDLE) && !flush;
  assign last        = (cnt_q == CNTW'(1));
  assign in_ready_o  = (state_q == MD_IDLE);
  assign out_valid_o = (state_q == MD_DONE);
  assign busy_o      = (state_q == MD_BUSY) || (state_q == MD_DONE);
  assign result_o    = result_q;

  // Divide-by-zero and signed overflow bypass the iteration entirely
  always_comb begin
    dvd_sx = wordop_i ? XLEN'($signed(op1_i[31:0])) : op1_i;
    div0   = wordop_i ? (op2_i[31:0] == 32'd0) : (op2_i == '0);
    ovf    = (op_i == MD_DIV || op_i == MD_REM) &&
             (wordop_i ? (op1_i[31:0] == 32'h8000_0000 && op2_i[31:0] == 32'hFFFF_FFFF)
                       : (op1_i == {1'b1, {(XLEN-1){1'b0}}} && (&op2_i)));
    special = md_is_div(op_i) && (div0 || ovf);
    if (div0) spec_res = md_is_rem(op_i) ? dvd_sx : '1;
    else      spec_res = md_is_rem(op_i) ? '0 : dvd_sx;
  end

  // One shift-add or restoring step, plus the raw value seen on the last step
  always_comb begin
    mul_sum     = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opb_q} : '0);
    mul_nxt     = {mul_sum, prod_q[XLEN-1:1]};
    div_shift   = {rem_q[XLEN-1:0], prod_q[XLEN-1]};
    div_diff    = div_shift - {1'b0, opb_q};
    div_rem_nxt = div_diff[XLEN] ? div_shift : div_diff;
    div_quo_nxt = {prod_q[XLEN-2:0], ~div_diff[XLEN]};
    fin_hi      = !md_is_div(op_q) && (op_q[1:0] != 2'b00);
    if (md_is_div(op_q)) begin
      fin_raw = md_is_rem(op_q) ? (2*XLEN)'(div_rem_nxt) : (2*XLEN)'(div_quo_nxt);
    end else begin
      // A 32-step word multiply leaves the product shifted up by XLEN-32
      fin_raw = word_q ? (mul_nxt >> (XLEN - 32)) : mul_nxt;
    end
  end

  // FSM next state; flush wins over everything else
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MD_IDLE: if (accept) state_d = special ? MD_DONE : MD_BUSY;
      MD_BUSY: if (last) state_d = MD_DONE;
      MD_DONE: if (out_ready_i) state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    if (flush) state_d = MD_IDLE;
  end

  // Datapath next state: latch on accept, iterate in BUSY, capture result at the end
  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    word_d   = word_q;
    neg_d    = neg_q;
    opb_d    = opb_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    result_d = result_q;
    if (state_q == MD_IDLE && accept) begin
      op_d   = op_i;
      word_d = wordop_i;
      neg_d  = md_is_rem(op_i) ? neg1 : (neg1 ^ neg2);
      if (special) begin
        result_d = spec_res;
      end else begin
        cnt_d = wordop_i ? CNTW'(32) : CNTW'(XLEN);
        rem_d = '0;
        if (md_is_div(op_i)) begin
          // Word dividends are pre-aligned so only 32 steps are needed
          opb_d  = abs2;
          prod_d = {{XLEN{1'b0}}, (wordop_i ? (abs1 << (XLEN - 32)) : abs1)};
        end else begin
          opb_d  = abs1;
          prod_d = {{XLEN{1'b0}}, abs2};
        end
      end
    end else if (state_q == MD_BUSY) begin
      cnt_d = cnt_q - CNTW'(1);
      if (md_is_div(op_q)) begin
        rem_d  = div_rem_nxt;
        prod_d = {prod_q[2*XLEN-1:XLEN], div_quo_nxt};
      end else begin
        prod_d = mul_nxt;
      end
      if (last) result_d = fin_res;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      opb_q    <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      word_q   <= word_d;
      neg_q    <= neg_d;
      opb_q    <= opb_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22040895_muldiv.sv
// Directed, table-driven bench for the multiply/divide unit (XLEN=64).
module tb_ysyx_22040895_muldiv;

  logic        clk = 1'b0;
  logic        rst;
`ifdef YSYX_22040895_MULDIV_FLUSH_EN
  logic        flush_i;
`endif
  logic        in_valid_i;
  logic        in_ready_o;
  logic [2:0]  op_i;
  logic        wordop_i;
  logic [63:0] op1_i;
  logic [63:0] op2_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [63:0] result_o;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ysyx_22040895_muldiv #(
    .XLEN (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef YSYX_22040895_MULDIV_FLUSH_EN
    .flush_i     (flush_i),
`endif
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .op_i        (op_i),
    .wordop_i    (wordop_i),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .busy_o      (busy_o)
  );

  typedef struct {
    logic [2:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Issue one operation, measure cycles from the accept edge to out_valid_o
  task automatic do_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic rdy,
                       output logic [63:0] res, output int lat);
    @(negedge clk);
    op_i        = op;
    wordop_i    = w;
    op1_i       = a;
    op2_i       = b;
    out_ready_i = rdy;
    in_valid_i  = 1'b1;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    lat = 1;
    while (!out_valid_o && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = result_o;
    if (rdy) @(posedge clk);
  endtask

  initial begin
    logic [63:0] res;
    logic [63:0] held;
    int          lat;

    vecs[0]  = '{3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
    vecs[1]  = '{3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[2]  = '{3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[3]  = '{3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 65};
    vecs[4]  = '{3'b101, 1'b1, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33};
    vecs[5]  = '{3'b101, 1'b0, 64'd5, 64'd0, '1, 1};
    vecs[6]  = '{3'b111, 1'b0, 64'd5, 64'd0, 64'd5, 1};
    vecs[7]  = '{3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1};
    vecs[8]  = '{3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1};
    vecs[9]  = '{3'b001, 1'b0, 64'h8000_0000_0000_0000, 64'd2, '1, 65};
    vecs[10] = '{3'b010, 1'b0, '1, '1, '1, 65};
    vecs[11] = '{3'b000, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33};
    vecs[12] = '{3'b110, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, '1, 33};
    vecs[13] = '{3'b100, 1'b1, 64'd5, 64'h0000_0001_0000_0000, '1, 1};
    vecs[14] = '{3'b111, 1'b1, 64'hABCD_0000_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 1};
    vecs[15] = '{3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
                 64'hFFFF_FFFF_8000_0000, 1};
    vecs[16] = '{3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 65};
    vecs[17] = '{3'b110, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65};
    vecs[18] = '{3'b100, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[19] = '{3'b000, 1'b0, 64'd0, 64'd12345, 64'd0, 65};

    rst         = 1'b1;
`ifdef YSYX_22040895_MULDIV_FLUSH_EN
    flush_i     = 1'b0;
`endif
    in_valid_i  = 1'b0;
    op_i        = '0;
    wordop_i    = 1'b0;
    op1_i       = '0;
    op2_i       = '0;
    out_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 64'(in_ready_o), 64'd1);
    check("reset out_valid", 64'(out_valid_o), 64'd0);
    check("reset busy", 64'(busy_o), 64'd0);
    check("reset result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      do_op(vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b, 1'b1, res, lat);
      check($sformatf("vec%0d result", i), res, vecs[i].exp);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    // Backpressure, with a stray request while busy that must be ignored
    @(negedge clk);
    op_i = 3'b000; wordop_i = 1'b0; op1_i = 64'd5; op2_i = 64'd6;
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    @(posedge clk);
    #1;
    op_i = 3'b100; op1_i = 64'd99; op2_i = 64'd3;
    repeat (5) @(posedge clk);
    #1;
    check("busy during op", 64'(busy_o), 64'd1);
    check("in_ready during op", 64'(in_ready_o), 64'd0);
    in_valid_i = 1'b0;
    lat = 6;
    while (!out_valid_o && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("bp latency", 64'(lat), 64'd65);
    held = result_o;
    check("bp result", held, 64'd30);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp hold valid c%0d", c), 64'(out_valid_o), 64'd1);
      check($sformatf("bp hold result c%0d", c), result_o, 64'd30);
      check($sformatf("bp hold in_ready c%0d", c), 64'(in_ready_o), 64'd0);
    end
    @(negedge clk);
    out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    out_ready_i = 1'b0;
    check("bp release in_ready", 64'(in_ready_o), 64'd1);
    check("bp release out_valid", 64'(out_valid_o), 64'd0);
    out_ready_i = 1'b1;

    // Reset mid-BUSY aborts the operation
    @(negedge clk);
    op_i = 3'b100; wordop_i = 1'b0; op1_i = 64'd1000; op2_i = 64'd7;
    in_valid_i = 1'b1;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst out_valid", 64'(out_valid_o), 64'd0);
    check("midrst in_ready", 64'(in_ready_o), 64'd1);
    check("midrst busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(3'b000, 1'b0, 64'd3, 64'd4, 1'b1, res, lat);
    check("post-reset mul result", res, 64'd12);
    check("post-reset mul latency", 64'(lat), 64'd65);

`ifdef YSYX_22040895_MULDIV_FLUSH_EN
    // Flush at iteration 10 drops the operation silently
    @(negedge clk);
    op_i = 3'b000; wordop_i = 1'b0; op1_i = 64'd9; op2_i = 64'd9;
    in_valid_i = 1'b1;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    check("flush in_ready", 64'(in_ready_o), 64'd1);
    check("flush busy", 64'(busy_o), 64'd0);
    begin
      logic seen;
      seen = 1'b0;
      repeat (80) begin
        @(posedge clk);
        #1;
        if (out_valid_o) seen = 1'b1;
      end
      check("flush no result", 64'(seen), 64'd0);
    end
    // Flush beats a same-cycle request
    @(negedge clk);
    in_valid_i = 1'b1;
    flush_i    = 1'b1;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    flush_i    = 1'b0;
    check("flush blocks accept", 64'(busy_o), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22040895_muldiv.md
Name: ysyx_22040895_muldiv

Overview:
- Iterative multiply/divide unit for the RV64M extension, parametrised in XLEN.
- Sits beside the combinational ALU in EXU; accepts one operation through a valid/ready handshake.
- Computes the result over several cycles (radix-2 shift-add multiply, restoring divide) and returns it through a second valid/ready handshake.
- Supports 32-bit word variants (MULW/DIVW/DIVUW/REMW/REMUW) with sign-extended results.

Parameters:
- XLEN, 64, operand/result width; legal values 32 or 64.
- CNTW, $clog2(XLEN+1), iteration counter width (derived, not overridden).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- in_valid_i  in  1  operation request
- in_ready_o  out  1  unit can accept (high only in IDLE)
- op_i  in  3  funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
- wordop_i  in  1  32-bit variant; legal only with op 000/100/101/110/111 and XLEN=64
- op1_i  in  XLEN  rs1 / dividend
- op2_i  in  XLEN  rs2 / divisor
- out_valid_o  out  1  result_o valid
- out_ready_i  in  1  consumer accepts result
- result_o  out  XLEN  result, held stable while out_valid_o=1 and out_ready_i=0
- busy_o  out  1  high in BUSY or DONE

Behaviour:
- Reset: FSM to IDLE; in_ready_o=1, out_valid_o=0, busy_o=0, result_o=0, counter=0, internal registers cleared. Reset mid-operation aborts it with no output.
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY on in_valid_i&&in_ready_o (cycle T). Operands, op and wordop are latched at T; inputs are ignored afterwards.
  - IDLE -> DONE directly at T for divide-by-zero and signed overflow; out_valid_o=1 at T+1.
  - BUSY runs N iterations: N=XLEN, or N=32 when wordop_i=1. BUSY -> DONE after the last iteration; out_valid_o=1 at T+N+1.
  - DONE -> IDLE on out_ready_i. in_ready_o=1 the following cycle; no same-cycle re-accept.
- Word operands: low 32 bits used; sign- or zero-extended to the working width per signedness. Final 32-bit result is sign-extended to XLEN.
- Signed ops: magnitudes are computed unsigned; result negated at completion.
  - mul/mulh: sign = s1^s2.
  - mulhsu: only op1 is signed.
  - div: quotient sign = s1^s2.
  - rem: sign follows dividend.
- Multiply: 2*XLEN product register; one shift-add per cycle. mul returns the low half; mulh/mulhsu/mulhu return the high half.
- Divide: restoring, one quotient bit per cycle. Remainder register is XLEN+1 bits wide.
- Divide-by-zero (divisor, or low 32 bits for word ops, equal 0): quotient = all ones (-1); remainder = dividend (sign-extended for word ops).
- Signed overflow (dividend = most negative, divisor = -1): quotient = dividend; remainder = 0.
- Multiply by zero is not special-cased; it takes the full N cycles.
- in_valid_i while not IDLE is ignored; the requester must hold the request until in_ready_o=1.

Optional Feature:
- Macro: YSYX_22040895_MULDIV_FLUSH_EN.
- With the macro defined: adds input flush_i (1 bit). flush_i=1 in any state forces IDLE next cycle and drops out_valid_o to 0 next cycle. flush_i has priority over acceptance in the same cycle, and the request is not taken.
- Without the macro: no flush_i port; only rst aborts an operation.

Decomposition:
- Shared package/include holds:
  - op encodings: MD_MUL..MD_REMU
  - FSM state encodings: MD_IDLE, MD_BUSY, MD_DONE
  - XLEN default
- One natural sub-module: ysyx_22040895_muldiv_sign. It is combinational and handles operand absolute value/extension plus final result negation/sign-extension. The main module keeps the FSM, counter and datapath registers.

Test Plan:
- mul, op1=7, op2=-3, XLEN=64, out_ready_i=1 -> result_o=0xFFFFFFFFFFFFFFEB; out_valid_o at T+65.
- mulhu, op1=op2=0xFFFFFFFFFFFFFFFF -> result_o=0xFFFFFFFFFFFFFFFE.
- div, op1=-7, op2=2 -> result_o=-3.
- rem, op1=-7, op2=2 -> result_o=-1.
- divuw, op1=0x00000000_80000000, op2=1 -> result_o=0xFFFFFFFF80000000; out_valid_o at T+33.
- divu, op2=0, op1=5 -> result_o=0xFFFFFFFFFFFFFFFF at T+1.
- remu, op2=0, op1=5 -> result_o=5 at T+1.
- div, op1=0x8000000000000000, op2=-1 -> result_o=0x8000000000000000.
- rem with the same operands -> result_o=0.
- Backpressure: hold out_ready_i=0 for 10 cycles after completion -> out_valid_o and result_o stable, in_ready_o=0. Then pulse out_ready_i -> in_ready_o=1 the next cycle.
- rst asserted mid-BUSY -> next cycle out_valid_o=0, in_ready_o=1; a new mul 3*4 then yields 12.
- With the flush macro: flush_i at iteration 10 -> IDLE next cycle and no result emitted.
